// File: rtl/sram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : sram_pkg                                                     |
// | Description : Shared definitions for the parametrised 1RW+1R SRAM model:   |
// |               port-0 write-mode codes, clear-FSM state type and the        |
// |               masked write-merge helper.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sram_pkg;

  // Port-0 behaviour while writing
  localparam int unsigned WM_READ_FIRST  = 0;
  localparam int unsigned WM_WRITE_FIRST = 1;
  localparam int unsigned WM_NO_CHANGE   = 2;

  // Widest word the merge helper handles; callers cast in and out of this width
  localparam int unsigned SRAM_MAX_WIDTH = 1024;

  // Post-reset clear engine states
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_t;

  // Bits set in bit_mask take new_word, the rest keep old_word
  function automatic logic [SRAM_MAX_WIDTH-1:0] sram_merge(
    input logic [SRAM_MAX_WIDTH-1:0] old_word,
    input logic [SRAM_MAX_WIDTH-1:0] new_word,
    input logic [SRAM_MAX_WIDTH-1:0] bit_mask
  );
    return (old_word & ~bit_mask) | (new_word & bit_mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_rd_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_rd_pipe                                                 |
// | Description : Read output stage for one SRAM port. Registers data, valid   |
// |               and a side flag; data holds when no valid result arrives.    |
// |               A second register stage is added when RD_LATENCY = 2.        |
// | Ports       : clk, rst_n        - clock, async active-low reset            |
// |               i_valid/i_data    - captured read result                     |
// |               i_flag            - side flag travelling with the result     |
// |               o_valid/o_data    - port output (data held while invalid)    |
// |               o_flag            - side flag, only high with o_valid        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sram_rd_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_flag,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_flag
);

  logic                  r_valid_a;
  logic [DATA_WIDTH-1:0] r_data_a;
  logic                  r_flag_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_a <= 1'b0;
      r_data_a  <= '0;
      r_flag_a  <= 1'b0;
    end else begin
      r_valid_a <= i_valid;
      r_flag_a  <= i_valid & i_flag;
      if (i_valid) begin
        r_data_a <= i_data;
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_two_stage
    logic                  r_valid_b;
    logic [DATA_WIDTH-1:0] r_data_b;
    logic                  r_flag_b;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid_b <= 1'b0;
        r_data_b  <= '0;
        r_flag_b  <= 1'b0;
      end else begin
        r_valid_b <= r_valid_a;
        r_flag_b  <= r_flag_a;
        if (r_valid_a) begin
          r_data_b <= r_data_a;
        end
      end
    end

    assign o_valid = r_valid_b;
    assign o_data  = r_data_b;
    assign o_flag  = r_flag_b;
  end else begin : g_one_stage
    assign o_valid = r_valid_a;
    assign o_data  = r_data_a;
    assign o_flag  = r_flag_a;
  end

endmodule
`default_nettype wire

// File: rtl/sram_1rw1r_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_1rw1r_param                                             |
// | Description : Parametrised single-clock 1RW+1R SRAM with lane write masks, |
// |               selectable port-0 write mode, 1 or 2 cycle read latency,     |
// |               port-1 forwarding on same-address write and an optional      |
// |               post-reset clear engine.                                     |
// | Ports       : clk, rst_n                  - clock, async active-low reset  |
// |               csb0/web0/wmask0/addr0/din0 - port-0 request (read/write)    |
// |               dout0/dvalid0               - port-0 read result             |
// |               csb1/addr1                  - port-1 read request            |
// |               dout1/dvalid1               - port-1 read result             |
// |               busy                        - clear engine active            |
// |               collision                   - port 1 read port 0's write addr|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned WMASK_WIDTH    = 8,
  parameter int unsigned WRITE_MODE     = WM_READ_FIRST,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              csb0,
  input  logic                              web0,
  input  logic [DATA_WIDTH/WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]             addr0,
  input  logic [DATA_WIDTH-1:0]             din0,
  output logic [DATA_WIDTH-1:0]             dout0,
  output logic                              dvalid0,
  input  logic                              csb1,
  input  logic [ADDR_WIDTH-1:0]             addr1,
  output logic [DATA_WIDTH-1:0]             dout1,
  output logic                              dvalid1,
  output logic                              busy,
  output logic                              collision
);

  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;
  localparam int unsigned NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;

  // Parameter sanity, rejected at elaboration
  if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
    $error("sram_1rw1r_param: RD_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_bad_mask
    $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end
  if (WRITE_MODE > WM_NO_CHANGE) begin : g_bad_mode
    $error("sram_1rw1r_param: WRITE_MODE must be 0, 1 or 2");
  end
  if (DATA_WIDTH > SRAM_MAX_WIDTH) begin : g_bad_width
    $error("sram_1rw1r_param: DATA_WIDTH exceeds SRAM_MAX_WIDTH");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  clr_state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic                  w_busy;

  logic                  w_req0;
  logic                  w_wr0;
  logic                  w_rd1;
  logic                  w_col;
  logic [DATA_WIDTH-1:0] w_bitmask;
  logic [DATA_WIDTH-1:0] w_old0;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_v0;
  logic [DATA_WIDTH-1:0] w_d0;
  logic [DATA_WIDTH-1:0] w_d1;

  logic                  r_s0_v0;
  logic [DATA_WIDTH-1:0] r_s0_d0;
  logic                  r_s0_v1;
  logic [DATA_WIDTH-1:0] r_s0_d1;
  logic                  r_s0_col;

  logic                  w_flag0;
  logic                  w_flag1;

  // ---------------------------------------------------------------- clear FSM
  // Walks addresses 0..DEPTH-1, one per cycle; leaving on the last address
  // makes busy fall on the same edge that clears DEPTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      r_clr_addr <= '0;
    end else if (r_state == CLEAR) begin
      r_clr_addr <= r_clr_addr + 1'b1;
      if (&r_clr_addr) begin
        r_state <= IDLE;
      end
    end
  end

  assign w_busy = (r_state == CLEAR);
  assign busy   = w_busy;

  // ---------------------------------------------------------- request decode
  assign w_req0 = ~w_busy & ~csb0;
  assign w_wr0  = w_req0 & ~web0;
  assign w_rd1  = ~w_busy & ~csb1;
  assign w_col  = w_wr0 & w_rd1 & (addr0 == addr1);

  for (genvar gi = 0; gi < NUM_WMASKS; gi++) begin : g_lane
    assign w_bitmask[gi*WMASK_WIDTH +: WMASK_WIDTH] = {WMASK_WIDTH{wmask0[gi]}};
  end

  assign w_old0   = r_mem[addr0];
  assign w_merged = DATA_WIDTH'(sram_merge(SRAM_MAX_WIDTH'(w_old0),
                                           SRAM_MAX_WIDTH'(din0),
                                           SRAM_MAX_WIDTH'(w_bitmask)));

  always_comb begin
    w_v0 = w_req0;
    w_d0 = w_old0;
    if (w_wr0) begin
      if (WRITE_MODE == WM_WRITE_FIRST) begin
        w_d0 = w_merged;
      end else if (WRITE_MODE == WM_NO_CHANGE) begin
        w_v0 = 1'b0;
      end
    end
  end

  // Port 1 sees the merged word when port 0 writes its address this cycle
  assign w_d1 = w_col ? w_merged : r_mem[addr1];

  // ------------------------------------------------------------------- array
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_clr_addr] <= '0;
    end else if (w_wr0) begin
      r_mem[addr0] <= w_merged;
    end
  end

  // Capture the array-side result on the request edge so the old word is
  // preserved for read-first; the output pipes add RD_LATENCY more edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0_v0  <= 1'b0;
      r_s0_d0  <= '0;
      r_s0_v1  <= 1'b0;
      r_s0_d1  <= '0;
      r_s0_col <= 1'b0;
    end else begin
      r_s0_v0  <= w_v0;
      r_s0_d0  <= w_d0;
      r_s0_v1  <= w_rd1;
      r_s0_d1  <= w_d1;
      r_s0_col <= w_col;
    end
  end

  // --------------------------------------------------------------- outputs
  sram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (r_s0_v0),
    .i_data  (r_s0_d0),
    .i_flag  (1'b0),
    .o_valid (dvalid0),
    .o_data  (dout0),
    .o_flag  (w_flag0)
  );

  sram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (r_s0_v1),
    .i_data  (r_s0_d1),
    .i_flag  (r_s0_col),
    .o_valid (dvalid1),
    .o_data  (dout1),
    .o_flag  (w_flag1)
  );

  // Port 0's flag lane is tied low, so only port 1 contributes
  assign collision = w_flag0 | w_flag1;

endmodule
`default_nettype wire

// File: tb/tb_sram_1rw1r_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sram_1rw1r_param                                          |
// | Description : Self-checking bench for sram_1rw1r_param. Three instances    |
// |               (read-first/lat1, write-first/lat2, no-change/lat1) share    |
// |               one stimulus stream and are compared every cycle against a   |
// |               word-level memory model, plus hand-computed literals.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sram_1rw1r_param;

  localparam int N     = 3;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int WM_OF  [N] = '{0, 1, 2};
  localparam int LAT_OF [N] = '{1, 2, 1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        csb0 = 1'b1;
  logic        web0 = 1'b1;
  logic [3:0]  wmask0 = '0;
  logic [AW-1:0] addr0 = '0;
  logic [31:0] din0 = '0;
  logic        csb1 = 1'b1;
  logic [AW-1:0] addr1 = '0;

  logic [31:0] dout0_a [N];
  logic        dvalid0_a [N];
  logic [31:0] dout1_a [N];
  logic        dvalid1_a [N];
  logic        busy_a [N];
  logic        col_a [N];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    sram_1rw1r_param #(
      .DATA_WIDTH     (32),
      .ADDR_WIDTH     (AW),
      .WMASK_WIDTH    (8),
      .WRITE_MODE     (WM_OF[gi]),
      .RD_LATENCY     (LAT_OF[gi]),
      .CLEAR_ON_RESET (1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .csb0      (csb0),
      .web0      (web0),
      .wmask0    (wmask0),
      .addr0     (addr0),
      .din0      (din0),
      .dout0     (dout0_a[gi]),
      .dvalid0   (dvalid0_a[gi]),
      .csb1      (csb1),
      .addr1     (addr1),
      .dout1     (dout1_a[gi]),
      .dvalid1   (dvalid1_a[gi]),
      .busy      (busy_a[gi]),
      .collision (col_a[gi])
    );
  end

  // ------------------------------------------------------------------ model
  typedef struct packed {
    logic        v0;
    logic [31:0] d0;
    logic        v1;
    logic [31:0] d1;
    logic        col;
  } res_t;

  res_t        line_q [N][2];   // results waiting out the read latency
  res_t        expo   [N];      // expected visible outputs
  logic [31:0] mem    [DEPTH];
  int          busy_cnt;
  bit          in_reset;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[u%0d] @%0t: got %h expected %h", name, inst, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    in_reset = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < N; i++) begin
      expo[i] = '0;
      line_q[i][0] = '0;
      line_q[i][1] = '0;
    end
  endtask

  task automatic model_release();
    in_reset = 1'b0;
    busy_cnt = DEPTH;
    for (int a = 0; a < DEPTH; a++) mem[a] = 32'h0;
  endtask

  task automatic model_edge();
    logic        dropped;
    logic        wr;
    logic [31:0] old_w;
    logic [31:0] merged;
    res_t        r;
    res_t        applied;
    if (in_reset) return;
    dropped = (busy_cnt > 0);
    if (dropped) busy_cnt--;
    wr     = !dropped && !csb0 && !web0;
    old_w  = mem[addr0];
    merged = old_w;
    for (int k = 0; k < 4; k++) if (wmask0[k]) merged[k*8 +: 8] = din0[k*8 +: 8];
    for (int i = 0; i < N; i++) begin
      r = '0;
      if (!dropped && !csb0) begin
        r.v0 = !(wr && WM_OF[i] == 2);
        r.d0 = (wr && WM_OF[i] == 1) ? merged : old_w;
      end
      if (!dropped && !csb1) begin
        r.v1  = 1'b1;
        r.col = wr && (addr0 == addr1);
        r.d1  = r.col ? merged : mem[addr1];
      end
      applied = line_q[i][LAT_OF[i]-1];
      line_q[i][1] = line_q[i][0];
      line_q[i][0] = r;
      expo[i].v0  = applied.v0;
      expo[i].v1  = applied.v1;
      expo[i].col = applied.v1 && applied.col;
      if (applied.v0) expo[i].d0 = applied.d0;
      if (applied.v1) expo[i].d1 = applied.d1;
    end
    if (wr) mem[addr0] = merged;
  endtask

  task automatic compare_all();
    logic exp_busy;
    exp_busy = in_reset || (busy_cnt > 0);
    for (int i = 0; i < N; i++) begin
      chk("dout0",     i, dout0_a[i],          expo[i].d0);
      chk("dvalid0",   i, 32'(dvalid0_a[i]),   32'(expo[i].v0));
      chk("dout1",     i, dout1_a[i],          expo[i].d1);
      chk("dvalid1",   i, 32'(dvalid1_a[i]),   32'(expo[i].v1));
      chk("collision", i, 32'(col_a[i]),       32'(expo[i].col));
      chk("busy",      i, 32'(busy_a[i]),      32'(exp_busy));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // --------------------------------------------------------------- stimulus
  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; wmask0 = '0;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
  endtask

  task automatic rd0(input logic [AW-1:0] a);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a;
  endtask

  task automatic rd1(input logic [AW-1:0] a);
    csb1 = 1'b0; addr1 = a;
  endtask

  // Steps until busy drops; reports busy cycles and port-1 valids seen meanwhile
  task automatic count_busy(output int n, output int dv);
    n  = 0;
    dv = 0;
    while (n < 100) begin
      step();
      n++;
      if (dvalid1_a[0]) dv++;
      if (!busy_a[0]) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int ndv;

    // ---- reset values
    idle();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("rst_dout0_lit", 0, dout0_a[0], 32'h0);
    chk("rst_busy_lit",  0, 32'(busy_a[0]), 32'h1);
    step();
    step();

    // ---- clear engine: busy for DEPTH cycles, port-1 read ignored meanwhile
    rst_n = 1'b1;
    model_release();
    rd1(5'd3);
    count_busy(nb, ndv);
    chk("clear_cycles_lit", 0, 32'(nb), 32'd32);
    chk("clear_no_dvalid1", 0, 32'(ndv), 32'd0);
    idle();

    // ---- every address reads zero after the clear
    for (int a = 0; a < DEPTH; a++) begin
      rd1(AW'(a));
      rd0(AW'(DEPTH - 1 - a));
      step();
    end
    idle();
    step();
    step();

    // ---- masked write merge, then both ports read the same address
    wr0(5'h10, 32'hDEADBEEF, 4'b1111); step();
    wr0(5'h10, 32'h11223344, 4'b0101); step();
    idle(); rd0(5'h10); rd1(5'h10); step();
    idle(); step();
    chk("merge_u0_dout1", 0, dout1_a[0], 32'hDE22BE44);
    chk("merge_u2_dout0", 2, dout0_a[2], 32'hDE22BE44);
    chk("same_addr_nocol", 0, 32'(col_a[0]), 32'h0);
    step();
    chk("merge_u1_dout1", 1, dout1_a[1], 32'hDE22BE44);

    // ---- write-mode behaviour on port 0
    wr0(5'd5, 32'hAAAA5555, 4'b1111); step();
    wr0(5'd5, 32'h12345678, 4'b1111); step();
    idle(); step();
    chk("rf_dout0",   0, dout0_a[0], 32'hAAAA5555);
    chk("rf_dvalid0", 0, 32'(dvalid0_a[0]), 32'h1);
    chk("nc_dvalid0", 2, 32'(dvalid0_a[2]), 32'h0);
    chk("nc_hold",    2, dout0_a[2], 32'hDE22BE44);
    step();
    chk("wf_dout0",   1, dout0_a[1], 32'h12345678);
    chk("wf_dvalid0", 1, 32'(dvalid0_a[1]), 32'h1);

    // ---- same-cycle collision forwarding
    wr0(5'd3, 32'hCAFEF00D, 4'b1111); rd1(5'd3); step();
    idle(); step();
    chk("col_dout1",   0, dout1_a[0], 32'hCAFEF00D);
    chk("col_pulse",   0, 32'(col_a[0]), 32'h1);
    chk("col_dvalid1", 0, 32'(dvalid1_a[0]), 32'h1);
    step();
    chk("col_one_cycle", 0, 32'(col_a[0]), 32'h0);
    chk("col_lat2_dout1", 1, dout1_a[1], 32'hCAFEF00D);
    chk("col_lat2_pulse", 1, 32'(col_a[1]), 32'h1);

    // partial-mask collision, no-op masked collision, different-address write
    wr0(5'd3, 32'h0000BEEF, 4'b0011); rd1(5'd3); step();
    wr0(5'd7, 32'h55555555, 4'b0000); rd1(5'd7); step();
    chk("col_partial_lit", 0, dout1_a[0], 32'hCAFEBEEF);
    wr0(5'd8, 32'h0BADF00D, 4'b1111); rd1(5'd9); step();
    idle(); rd0(5'd8); rd1(5'd3); step();
    idle(); step(); step(); step();

    // ---- latency-2 streaming on port 1
    for (int i = 0; i < 8; i++) begin
      wr0(AW'(i), 32'h100 + i, 4'b1111);
      step();
    end
    idle(); step(); step(); step();
    for (int k = 0; k < 11; k++) begin
      idle();
      if (k < 8) rd1(AW'(k));
      step();
      if (k < 2) begin
        chk("lat2_not_yet", 1, 32'(dvalid1_a[1]), 32'h0);
      end else if (k < 10) begin
        chk("lat2_dvalid1", 1, 32'(dvalid1_a[1]), 32'h1);
        chk("lat2_dout1",   1, dout1_a[1], 32'h100 + k - 2);
      end
    end

    // ---- asynchronous reset with non-zero outputs, no clock edge needed
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("async_rst_dout1", 1, dout1_a[1], 32'h0);
    chk("async_rst_dout0", 0, dout0_a[0], 32'h0);
    step();
    rst_n = 1'b1;
    model_release();

    // ---- reset in the middle of the clear restarts it from address 0
    repeat (7) step();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("midclr_busy", 0, 32'(busy_a[0]), 32'h1);
    step();
    step();
    rst_n = 1'b1;
    model_release();
    count_busy(nb, ndv);
    chk("midclr_cycles_lit", 0, 32'(nb), 32'd32);
    idle(); rd1(5'd5); step();
    idle(); step();
    chk("reclear_dvalid1", 0, 32'(dvalid1_a[0]), 32'h1);
    chk("reclear_dout1",   0, dout1_a[0], 32'h0);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
